// File: rtl/bf_io_port.sv
// bf_io_port: byte I/O peripheral for the BF machine.
//   Output side: bytes pushed by the control unit (ld_out) are queued in an
//   OUT_DEPTH-entry FIFO and drained over ext_out_data/valid/ready.
//   Input side: one external byte is captured into a holding register over
//   ext_in_data/valid/ready and handed to the datapath on in_req.
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   ld_out, out_data                  push request and byte from control/datapath
//   out_full, out_empty, out_ovf      FIFO status, sticky overflow flag
//   ext_out_data/valid/ready          external output stream
//   in_req, in_valid, in_data         datapath input handshake
//   ext_in_data/valid/ready           external input stream
//   ext_in_eof                        only with BF_IO_EOF_ZERO_EN: source exhausted,
//                                     reads return 0 while nothing is held
module bf_io_port #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ld_out,
    input  logic [DATA_W-1:0] out_data,
    output logic              out_full,
    output logic              out_empty,
    output logic              out_ovf,
    output logic [DATA_W-1:0] ext_out_data,
    output logic              ext_out_valid,
    input  logic              ext_out_ready,
    input  logic              in_req,
    output logic              in_valid,
    output logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] ext_in_data,
    input  logic              ext_in_valid,
    output logic              ext_in_ready
`ifdef BF_IO_EOF_ZERO_EN
    ,
    input  logic              ext_in_eof
`endif
);

    localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // ---------------- output FIFO ----------------
    logic [DATA_W-1:0] mem [OUT_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;

    // Status decoded from registered count only
    assign out_full      = (count == CNT_W'(OUT_DEPTH));
    assign out_empty     = (count == '0);
    assign ext_out_valid = !out_empty;
    assign ext_out_data  = mem[rd_ptr];

    // A push while full is dropped even if a pop frees a slot this cycle
    assign push = ld_out && !out_full;
    assign pop  = ext_out_valid && ext_out_ready;

    // Pointer, occupancy and overflow tracking; pointers wrap at OUT_DEPTH
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            out_ovf <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (ld_out && out_full) out_ovf <= 1'b1;
        end
    end

    // Storage write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(OUT_DEPTH); i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= out_data;
        end
    end

    // ---------------- input holder ----------------
    typedef enum logic {IN_EMPTY, IN_HELD} in_state_t;

    in_state_t         in_state;
    logic [DATA_W-1:0] hold_reg;

    // Capture in IN_EMPTY, consume in IN_HELD; never both in one cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_state <= IN_EMPTY;
            hold_reg <= '0;
        end else begin
            case (in_state)
                IN_EMPTY: begin
                    if (ext_in_valid) begin
                        hold_reg <= ext_in_data;
                        in_state <= IN_HELD;
                    end
                end
                IN_HELD: begin
                    if (in_req) in_state <= IN_EMPTY;
                end
                default: in_state <= IN_EMPTY;
            endcase
        end
    end

    assign ext_in_ready = (in_state == IN_EMPTY);

    // in_data is 0 unless a byte is held, which doubles as the EOF value
    assign in_data = (in_state == IN_HELD) ? hold_reg : '0;

`ifdef BF_IO_EOF_ZERO_EN
    // A held byte wins; otherwise EOF presents a zero without leaving IN_EMPTY
    assign in_valid = (in_state == IN_HELD) || ext_in_eof;
`else
    assign in_valid = (in_state == IN_HELD);
`endif

endmodule

// File: tb/tb_bf_io_port.sv
module tb_bf_io_port;

    logic       clk;
    logic       resetn;
    logic       ld_out;
    logic [7:0] out_data;
    logic       out_full;
    logic       out_empty;
    logic       out_ovf;
    logic [7:0] ext_out_data;
    logic       ext_out_valid;
    logic       ext_out_ready;
    logic       in_req;
    logic       in_valid;
    logic [7:0] in_data;
    logic [7:0] ext_in_data;
    logic       ext_in_valid;
    logic       ext_in_ready;
`ifdef BF_IO_EOF_ZERO_EN
    logic       ext_in_eof;
`endif

    int n_cmp;
    int n_err;

    bf_io_port #(.DATA_W(8), .OUT_DEPTH(4)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .ld_out        (ld_out),
        .out_data      (out_data),
        .out_full      (out_full),
        .out_empty     (out_empty),
        .out_ovf       (out_ovf),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .in_req        (in_req),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready)
`ifdef BF_IO_EOF_ZERO_EN
        ,
        .ext_in_eof    (ext_in_eof)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_full"},   32'(out_full),      32'd0);
        chk({tag, "_empty"},  32'(out_empty),     32'd1);
        chk({tag, "_ovf"},    32'(out_ovf),       32'd0);
        chk({tag, "_ovalid"}, 32'(ext_out_valid), 32'd0);
        chk({tag, "_ivalid"}, 32'(in_valid),      32'd0);
        chk({tag, "_idata"},  32'(in_data),       32'd0);
        chk({tag, "_iready"}, 32'(ext_in_ready),  32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        resetn = 1'b0;
        ld_out = 1'b0;
        out_data = 8'h00;
        ext_out_ready = 1'b0;
        in_req = 1'b0;
        ext_in_data = 8'h00;
        ext_in_valid = 1'b0;
`ifdef BF_IO_EOF_ZERO_EN
        ext_in_eof = 1'b0;
`endif
        #23;
        chk_reset_vals("rst");
        resetn = 1'b1;
        cyc();

        // Three pushes with consumer stalled
        ld_out = 1'b1; out_data = 8'h41; cyc();
        out_data = 8'h42; cyc();
        out_data = 8'h43; cyc();
        ld_out = 1'b0;
        chk("q3_valid", 32'(ext_out_valid), 32'd1);
        chk("q3_full",  32'(out_full),      32'd0);
        chk("q3_head",  32'(ext_out_data),  32'h41);
        ext_out_ready = 1'b1;
        cyc(); chk("drain_42", 32'(ext_out_data), 32'h42);
        cyc(); chk("drain_43", 32'(ext_out_data), 32'h43);
        cyc(); chk("drain_empty", 32'(out_empty), 32'd1);
        chk("drain_valid0", 32'(ext_out_valid), 32'd0);
        ext_out_ready = 1'b0;

        // Fill, then push while full with a simultaneous pop
        ld_out = 1'b1;
        out_data = 8'h11; cyc();
        out_data = 8'h22; cyc();
        out_data = 8'h33; cyc();
        out_data = 8'h44; cyc();
        chk("full_flag", 32'(out_full), 32'd1);
        chk("full_head", 32'(ext_out_data), 32'h11);
        chk("ovf_pre",   32'(out_ovf), 32'd0);
        out_data = 8'h55; ext_out_ready = 1'b1; cyc();
        ld_out = 1'b0;
        chk("ovf_set",   32'(out_ovf), 32'd1);
        chk("ovf_head22", 32'(ext_out_data), 32'h22);
        chk("ovf_notfull", 32'(out_full), 32'd0);
        cyc(); chk("ovf_head33", 32'(ext_out_data), 32'h33);
        cyc(); chk("ovf_head44", 32'(ext_out_data), 32'h44);
        cyc(); chk("ovf_drained", 32'(out_empty), 32'd1);
        chk("ovf_sticky1", 32'(out_ovf), 32'd1);
        ext_out_ready = 1'b0;

        // Sustained push+pop at occupancy 1 across the pointer wrap
        ld_out = 1'b1; out_data = 8'h60; cyc();
        ext_out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            out_data = 8'(8'h60 + i);
            chk($sformatf("stream_head%0d", i), 32'(ext_out_data), 32'(8'h60 + i - 1));
            chk($sformatf("stream_nonempty%0d", i), 32'(out_empty), 32'd0);
            cyc();
        end
        ld_out = 1'b0;
        chk("stream_last", 32'(ext_out_data), 32'h6A);
        chk("stream_notfull", 32'(out_full), 32'd0);
        cyc();
        chk("stream_empty", 32'(out_empty), 32'd1);
        chk("ovf_sticky2", 32'(out_ovf), 32'd1);
        ext_out_ready = 1'b0;

        // Input capture and consume
        in_req = 1'b1; cyc();
        chk("inreq_empty_noeffect", 32'(in_valid), 32'd0);
        in_req = 1'b0;
        ext_in_valid = 1'b1; ext_in_data = 8'h2C;
        chk("in_ready_pre", 32'(ext_in_ready), 32'd1);
        cyc();
        ext_in_valid = 1'b0; ext_in_data = 8'hEE;
        chk("in_valid1", 32'(in_valid),     32'd1);
        chk("in_data2C", 32'(in_data),      32'h2C);
        chk("in_ready0", 32'(ext_in_ready), 32'd0);
        ext_in_valid = 1'b1; cyc();
        ext_in_valid = 1'b0;
        chk("in_hold_data", 32'(in_data), 32'h2C);
        in_req = 1'b1; cyc();
        in_req = 1'b0;
        chk("in_consumed_valid", 32'(in_valid),     32'd0);
        chk("in_consumed_ready", 32'(ext_in_ready), 32'd1);

        // Asynchronous reset with 2 bytes buffered and a byte held
        ld_out = 1'b1; out_data = 8'hA1; cyc();
        out_data = 8'hA2; ext_in_valid = 1'b1; ext_in_data = 8'h99; cyc();
        ld_out = 1'b0; ext_in_valid = 1'b0;
        chk("prerst_valid", 32'(ext_out_valid), 32'd1);
        chk("prerst_held",  32'(in_data),       32'h99);
        #2;
        resetn = 1'b0;
        #1;
        chk_reset_vals("arst");
        #3;
        resetn = 1'b1;
        cyc();
        chk("postrst_empty", 32'(out_empty), 32'd1);
        chk("postrst_ivalid", 32'(in_valid), 32'd0);

`ifdef BF_IO_EOF_ZERO_EN
        // EOF returns zero while empty; a held byte takes priority
        ext_in_eof = 1'b1;
        #1;
        chk("eof_valid", 32'(in_valid), 32'd1);
        chk("eof_zero",  32'(in_data),  32'h00);
        ext_in_valid = 1'b1; ext_in_data = 8'h07; cyc();
        ext_in_valid = 1'b0;
        chk("eof_held_data",  32'(in_data),  32'h07);
        chk("eof_held_valid", 32'(in_valid), 32'd1);
        in_req = 1'b1; cyc();
        in_req = 1'b0;
        chk("eof_after_zero",  32'(in_data),      32'h00);
        chk("eof_after_ready", 32'(ext_in_ready), 32'd1);
        ext_in_eof = 1'b0;
        #1;
        chk("eof_off_valid", 32'(in_valid), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bf_io_port.md
# bf_io_port

Byte I/O port for the BF machine: the peripheral end of the control unit's `.` (LdOut) and `,` (DInChoose) commands. It sits between the datapath and the outside world. Output bytes loaded by the control FSM are buffered in a small FIFO and drained over a valid/ready interface. Input bytes arrive over a valid/ready interface, are held in a one-byte register, and are handed to the datapath when the control FSM requests input.

## Interface
Parameters:
- DATA_W, 8, width of a data cell / I/O byte
- OUT_DEPTH, 4, output FIFO depth; a power of 2, at least 2

Ports:
- clk  in  1  system clock; all state changes on rising edge
- resetn  in  1  asynchronous, active-low reset
- ld_out  in  1  push request from control; one cycle per `.` command
- out_data  in  DATA_W  byte to push, the current cell value from the datapath
- out_full  out  1  FIFO holds OUT_DEPTH entries; control must not assert ld_out while high
- out_empty  out  1  FIFO holds 0 entries
- out_ovf  out  1  sticky flag: a push was attempted while full
- ext_out_data  out  DATA_W  head-of-FIFO byte
- ext_out_valid  out  1  FIFO not empty
- ext_out_ready  in  1  external consumer accepts the head byte
- in_req  in  1  control is waiting in its `,` state
- in_valid  out  1  a byte is available on in_data
- in_data  out  DATA_W  byte written to the cell when in_req and in_valid are both high
- ext_in_data  in  DATA_W  external input byte
- ext_in_valid  in  1  ext_in_data is valid
- ext_in_ready  out  1  the holding register is empty
- ext_in_eof  in  1  external source is exhausted; present only when BF_IO_EOF_ZERO_EN is defined

## Operation
Output FIFO:
- Storage is OUT_DEPTH registers, with rd_ptr/wr_ptr of log2(OUT_DEPTH) bits that wrap modulo OUT_DEPTH, and count of log2(OUT_DEPTH)+1 bits.
- Push: ld_out && !out_full (fullness evaluated at the start of the cycle). mem[wr_ptr] <= out_data and wr_ptr increments.
- Pop: ext_out_valid && ext_out_ready. rd_ptr increments.
- Push and pop in the same cycle with count in 1..OUT_DEPTH-1: both occur and count is unchanged.
- ld_out while full is dropped, even if a pop occurs in the same cycle. out_ovf is set to 1 and FIFO contents are unaffected.
- Pop while empty is impossible, because ext_out_valid=0.
- ext_out_data = mem[rd_ptr], combinational from storage. Its value is don't-care while empty.

Input holder (FSM with states IN_EMPTY and IN_HELD):
- IN_EMPTY: ext_in_ready=1. ext_in_valid captures hold_reg <= ext_in_data and moves to IN_HELD.
- IN_HELD: ext_in_ready=0, in_valid=1, in_data=hold_reg. in_req consumes the byte and returns to IN_EMPTY. A consume and a capture never occur in the same cycle.
- in_req in IN_EMPTY has no effect. The control stalls until in_valid rises.

Reset (asynchronous, any time):
- count=0, both pointers 0, out_ovf=0, FSM=IN_EMPTY, hold_reg=0.
- Reset values of outputs: out_full=0, out_empty=1, ext_out_valid=0, in_valid=0, in_data=0, ext_in_ready=1.
- FIFO contents and any in-flight transfer are discarded.

## Timing
- Push to ext_out_valid: 1 cycle, since the byte is visible the cycle after the ld_out edge.
- Byte-to-byte throughput of the output FIFO is 1 per cycle.
- ext_in capture to in_valid: 1 cycle.
- Input throughput is 1 byte per 2 cycles, because the port is not ready again until the cycle after a consume.
- out_full, out_empty and ext_out_valid are decoded from registered count with no combinational path from ld_out. ext_in_ready is registered state.
- With the EOF option, in_valid depends combinationally on ext_in_eof.

## Configuration
BF_IO_EOF_ZERO_EN:
- Defined: the ext_in_eof port exists. In IN_EMPTY with ext_in_eof=1, in_valid=1 and in_data=0, so `,` stores 0 and the program continues. The FSM stays in IN_EMPTY. A held byte always takes priority over EOF.
- Undefined: the port is absent, and in_req in IN_EMPTY waits indefinitely.

## Test plan
- Reset, then ld_out with 0x41, 0x42, 0x43 while ext_out_ready=0 -> count=3, ext_out_data=0x41. Raising ready -> 0x41, 0x42, 0x43 appear on consecutive cycles, then out_empty=1.
- Push 4 bytes (full), then ld_out 0x55 with ready=1 -> 0x55 is dropped, out_ovf=1 and stays 1 through further traffic. The FIFO drains the original 4 bytes in order.
- Sustained push and pop every cycle across 10 bytes -> count is constant, the pointers wrap past 3, and the data order is preserved.
- ext_in_valid with 0x2C -> next cycle in_valid=1, in_data=0x2C, ext_in_ready=0. in_req -> next cycle in_valid=0, ext_in_ready=1.
- Assert resetn=0 asynchronously mid-cycle with 2 bytes buffered and a byte held -> all outputs immediately take their reset values.
- With BF_IO_EOF_ZERO_EN defined, ext_in_eof=1 and IN_EMPTY -> in_valid=1, in_data=0x00. Then capture 0x07 while eof=1 -> in_data=0x07.
